// File: rtl/rx_byte_packer.sv
// rtl/rx_byte_packer.sv - repacks compacted RX beats into full words behind a FWFT output FIFO
// Optional packet byte-length reporting is enabled by defining RX_PACKER_PKTLEN_EN.
module rx_byte_packer #(
  parameter  int DATA_WIDTH = 64,
  parameter  int FIFO_DEPTH = 16,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int CW         = $clog2(BYTES + 1),
  localparam int LW         = $clog2(FIFO_DEPTH + 1),
  localparam int PW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CW-1:0]         in_cnt,
  input  logic                  in_last,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [BYTES-1:0]      m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic [LW-1:0]         fifo_level,
  output logic                  drop_pulse
`ifdef RX_PACKER_PKTLEN_EN
  ,
  output logic [15:0]           pkt_len,
  output logic                  pkt_len_valid
`endif
);
  // FIFO entry layout: {tuser, tlast, tkeep, tdata}
  localparam int EW = DATA_WIDTH + BYTES + 2;

  typedef enum logic {PASS, DROP} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic [CW-1:0]           res_cnt_q, res_cnt_d;
  logic                    pkt_open_q, pkt_open_d;
  logic                    term_pend_q, term_pend_d;
  logic                    last_seen_q, last_seen_d;

  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           count_q;

  logic [DATA_WIDTH-1:0]   in_masked;
  logic [2*DATA_WIDTH-1:0] comb;
  logic [CW:0]             total, rem;
  logic                    full, need_tail, pop, accept, done;
  logic [1:0]              k, n_push;
  logic [LW:0]             free;
  logic [BYTES-1:0]        tail_keep;
  logic [DATA_WIDTH-1:0]   tail_data;
  logic [EW-1:0]           w0, w1;

  assign m_tvalid   = count_q != '0;
  assign fifo_level = count_q;
  assign pop        = m_tvalid && m_tready;
  assign {m_tuser, m_tlast, m_tkeep, m_tdata} = mem[rd_ptr_q];
  assign free = (LW+1)'(FIFO_DEPTH) - {1'b0, count_q} + (LW+1)'(pop);

  // Invalid upper input bytes are zeroed so the residue never carries garbage.
  always_comb begin
    in_masked = '0;
    tail_keep = '0;
    total     = {1'b0, res_cnt_q} + {1'b0, in_cnt};
    full      = total >= (CW+1)'(BYTES);
    rem       = full ? total - (CW+1)'(BYTES) : total;
    for (int b = 0; b < BYTES; b++) begin
      if (CW'(b) < in_cnt) in_masked[8*b +: 8] = in_data[8*b +: 8];
      tail_keep[b] = (CW+1)'(b) < rem;
    end
    comb      = {{DATA_WIDTH{1'b0}}, res_q}
              | ({{DATA_WIDTH{1'b0}}, in_masked} << {res_cnt_q, 3'b000});
    tail_data = full ? comb[2*DATA_WIDTH-1:DATA_WIDTH] : comb[DATA_WIDTH-1:0];
    need_tail = in_last && ((rem != '0) || ((total == '0) && pkt_open_q));
    k         = {1'b0, full} + {1'b0, need_tail};
  end

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    res_cnt_d   = res_cnt_q;
    pkt_open_d  = pkt_open_q;
    term_pend_d = term_pend_q;
    last_seen_d = last_seen_q;
    drop_pulse  = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    n_push      = 2'd0;
    w0          = '0;
    w1          = '0;
    case (state_q)
      PASS: begin
        if (in_valid && ((in_cnt != '0) || in_last)) begin
          if ((LW+1)'(k) > free) begin
            drop_pulse  = 1'b1;
            res_d       = '0;
            res_cnt_d   = '0;
            pkt_open_d  = 1'b0;
            term_pend_d = 1'b1;
            last_seen_d = in_last;
            state_d     = DROP;
          end else begin
            accept = 1'b1;
            n_push = k;
            if (full) begin
              w0 = {1'b0, in_last && !need_tail, {BYTES{1'b1}}, comb[DATA_WIDTH-1:0]};
              w1 = {1'b0, 1'b1, tail_keep, tail_data};
            end else begin
              w0 = {1'b0, 1'b1, tail_keep, tail_data};
            end
            if (in_last) begin
              res_d      = '0;
              res_cnt_d  = '0;
              pkt_open_d = 1'b0;
            end else begin
              res_d      = tail_data;
              res_cnt_d  = rem[CW-1:0];
              pkt_open_d = pkt_open_q || full;
            end
          end
        end
      end
      DROP: begin
        drop_pulse = in_valid;
        done       = !term_pend_q;
        if (term_pend_q && (free != '0)) begin
          n_push      = 2'd1;
          w0          = {1'b1, 1'b1, {BYTES{1'b0}}, {DATA_WIDTH{1'b0}}};
          term_pend_d = 1'b0;
          done        = 1'b1;
        end
        // A last seen before the terminator could be queued still closes the dropped packet.
        if (done && (last_seen_q || (in_valid && in_last))) begin
          state_d     = PASS;
          last_seen_d = 1'b0;
        end else if (in_valid && in_last) begin
          last_seen_d = 1'b1;
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PASS;
      res_q       <= '0;
      res_cnt_q   <= '0;
      pkt_open_q  <= 1'b0;
      term_pend_q <= 1'b0;
      last_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      res_cnt_q   <= res_cnt_d;
      pkt_open_q  <= pkt_open_d;
      term_pend_q <= term_pend_d;
      last_seen_q <= last_seen_d;
      wr_ptr_q    <= wr_ptr_q + PW'(n_push);
      rd_ptr_q    <= rd_ptr_q + PW'(pop);
      count_q     <= count_q + LW'(n_push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wr_ptr_q] <= w0;
    if (n_push == 2'd2) mem[wr_ptr_q + PW'(1)] <= w1;
  end

`ifdef RX_PACKER_PKTLEN_EN
  logic [15:0] bytes_q, pkt_len_q, bytes_acc;
  logic [16:0] sum;
  logic        tlast_push;

  always_comb begin
    sum        = {1'b0, bytes_q} + 17'(in_cnt);
    bytes_acc  = sum[16] ? 16'hFFFF : sum[15:0];
    tlast_push = accept && in_last && (k != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bytes_q   <= '0;
      pkt_len_q <= '0;
    end else begin
      if (accept) bytes_q <= in_last ? 16'h0 : bytes_acc;
      else if (drop_pulse) bytes_q <= '0;
      if (tlast_push) pkt_len_q <= bytes_acc;
    end
  end

  assign pkt_len_valid = tlast_push;
  assign pkt_len       = tlast_push ? bytes_acc : pkt_len_q;
`endif

endmodule
